ijtag_sib_network: RTL and testbench
====================================

Name: ijtag_sib_network

Overview:
- IEEE 1687 Segment Insertion Bit (SIB) network between the TAP controller's IJTAG port and up to N internal instruments.
- A serial chain of N SIBs, all on TCK, opens or closes each instrument's scan segment on the active scan path.
- Gates capture/shift/update to open segments only, so the TAP drives many instruments through one IJTAG_ACCESS data register.
- Rejects opening a segment whose instrument reports not-ready, and records the attempt.

Parameters:
N_SEG, 4, number of SIBs / instrument segments (1..16)

Ports:
TCK  in  1  test clock; all state updates on posedge
TRST_n  in  1  reset, asynchronous, active-low
ijtag_select  in  1  IJTAG_ACCESS instruction active (from TAP)
ijtag_capture  in  1  Capture-DR qualified by select
ijtag_shift  in  1  Shift-DR qualified by select
ijtag_update  in  1  Update-DR qualified by select
ijtag_tdi  in  1  scan data from TAP
ijtag_tdo  out  1  scan data to TAP (= sib_shift[N_SEG-1])
inst_ready  in  N_SEG  instrument i powered/clocked and accessible
inst_tdo  in  N_SEG  scan-out of instrument i
inst_select  out  N_SEG  ijtag_select & sib_upd[i]
inst_capture  out  N_SEG  ijtag_capture & sib_upd[i]
inst_shift  out  N_SEG  ijtag_shift & sib_upd[i]
inst_update  out  N_SEG  ijtag_update & sib_upd[i]
inst_tdi  out  N_SEG  scan-in to instrument i (= seg_in[i])
sib_open  out  N_SEG  sib_upd, current open/closed state
sib_err  out  N_SEG  sticky: open attempted while inst_ready[i]=0

Behaviour:
- State per SIB i: sib_shift[i] (shift stage), sib_upd[i] (update stage, 1 = open), sib_err[i].
- Reset (TRST_n=0, async):
  - sib_shift, sib_upd and sib_err all 0.
  - All inst_* outputs 0; ijtag_tdo 0.
  - Applies mid-scan as well: every open segment is removed immediately.
- Scan path, combinational:
  - seg_in[0] = ijtag_tdi; seg_in[i] = sib_shift[i-1] for i>0.
  - seg_out[i] = sib_upd[i] ? inst_tdo[i] : seg_in[i]. The open segment is inserted before its SIB bit.
  - ijtag_tdo = sib_shift[N_SEG-1]. This is registered, so there is no combinational path from TDI to TDO.
- Active path length = N_SEG + sum of the lengths of open instrument segments.
- Posedge TCK with ijtag_select=1, priority capture > shift > update. Only one is asserted per cycle in legal TAP operation.
  - Capture: sib_shift[i] <= sib_upd[i]. Reads back the current open state.
  - Shift: sib_shift[i] <= seg_out[i], all i in parallel. The first TDI bit reaches sib_shift[N_SEG-1] after the full path length.
  - Update, when sib_shift[i]=1 and inst_ready[i]=1: sib_upd[i] <= 1.
  - Update, when sib_shift[i]=1 and inst_ready[i]=0: sib_upd[i] <= 0 and sib_err[i] <= 1.
  - Update, when sib_shift[i]=0: sib_upd[i] <= 0 (close).
- ijtag_select=0: all state holds, and all inst_* gating outputs are 0 regardless of sib_upd.
- inst_ready[i] dropping while segment i is open:
  - sib_upd[i] is cleared on the next posedge TCK, independent of select.
  - sib_err[i] is set.
  - Keeps dead instruments off the path.
- Timing of open/close:
  - A change in sib_upd takes effect in the cycle after Update-DR.
  - The gating of inst_update during that Update-DR cycle uses the pre-update sib_upd.
  - An instrument being closed therefore still receives its final update.
- sib_err is cleared only by TRST_n.
- Not a free-running FSM: sequencing is driven entirely by the TAP state signals. The per-SIB {closed, open} state is captured in sib_upd.

Test Plan:
1. Reset then capture, shift 4 (N_SEG=4) -> ijtag_tdo sequence 0,0,0,0; sib_open=0000; all inst_* outputs 0.
2. Shift TDI 0,0,0,1 (time order), then update, with inst_ready=1111 -> sib_open=0001 and inst_select=0001 the next cycle. A following capture+shift through an 8-bit instrument 0 needs a 12-bit path; the SIB0 read-back bit appears on ijtag_tdo at shift cycle 4.
3. Open SIB2 with inst_ready[2]=0 -> sib_open[2]=0, sib_err=0100; sib_err persists through later scans until TRST_n.
4. SIB1 open, then inst_ready[1] dropped mid-shift -> sib_open[1]=0 and sib_err[1]=1 on the next posedge.
5. SIB3 open, shift 0 into SIB3, then update -> inst_update[3]=1 during the Update-DR cycle, then sib_open[3]=0.
6. TRST_n asserted mid Shift-DR with SIBs 0 and 2 open -> sib_open=0000, inst_shift=0000 and ijtag_tdo=0 asynchronously.

Source files
------------

// File: rtl/ijtag_sib_network.sv
// IJTAG SIB network: a serial chain of Segment Insertion Bits that splices
// instrument scan segments into the IJTAG_ACCESS data register path.
// Each SIB has a shift stage, an update stage (1 = segment open) and a
// sticky error flag raised when an open is refused or an open instrument
// stops reporting ready. All sequencing comes from the TAP state strobes.
module ijtag_sib_network #(
  parameter int N_SEG = 4
) (
  input  logic             TCK,
  input  logic             TRST_n,
  input  logic             ijtag_select,
  input  logic             ijtag_capture,
  input  logic             ijtag_shift,
  input  logic             ijtag_update,
  input  logic             ijtag_tdi,
  output logic             ijtag_tdo,
  input  logic [N_SEG-1:0] inst_ready,
  input  logic [N_SEG-1:0] inst_tdo,
  output logic [N_SEG-1:0] inst_select,
  output logic [N_SEG-1:0] inst_capture,
  output logic [N_SEG-1:0] inst_shift,
  output logic [N_SEG-1:0] inst_update,
  output logic [N_SEG-1:0] inst_tdi,
  output logic [N_SEG-1:0] sib_open,
  output logic [N_SEG-1:0] sib_err
);

  logic [N_SEG-1:0] sib_shift_q, sib_shift_d;
  logic [N_SEG-1:0] sib_upd_q,   sib_upd_d;
  logic [N_SEG-1:0] sib_err_q,   sib_err_d;

  logic [N_SEG:0]   chain;
  logic [N_SEG-1:0] seg_in;
  logic [N_SEG-1:0] seg_out;
  logic [N_SEG-1:0] dead;
  logic [N_SEG-1:0] refused;

  // Scan path: each segment's input is the previous SIB (or TDI); an open
  // segment inserts the instrument ahead of its own SIB bit.
  always_comb begin
    chain   = {sib_shift_q, ijtag_tdi};
    seg_in  = chain[N_SEG-1:0];
    seg_out = (sib_upd_q & inst_tdo) | (~sib_upd_q & seg_in);
  end

  // Open segments whose instrument dropped ready, and open requests refused
  // because the instrument is not ready.
  always_comb begin
    dead    = sib_upd_q & ~inst_ready;
    refused = sib_shift_q & ~inst_ready;
  end

  // Next-state: capture > shift > update under select; a dead instrument is
  // pulled off the path on every edge regardless of select.
  always_comb begin
    sib_shift_d = sib_shift_q;
    sib_upd_d   = sib_upd_q;
    sib_err_d   = sib_err_q;

    if (ijtag_select) begin
      if (ijtag_capture) begin
        sib_shift_d = sib_upd_q;
      end else if (ijtag_shift) begin
        sib_shift_d = seg_out;
      end else if (ijtag_update) begin
        sib_upd_d = sib_shift_q & inst_ready;
        sib_err_d = sib_err_q | refused;
      end
    end

    sib_upd_d = sib_upd_d & ~dead;
    sib_err_d = sib_err_d | dead;
  end

  // SIB state registers, cleared asynchronously by TRST_n.
  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      sib_shift_q <= '0;
      sib_upd_q   <= '0;
      sib_err_q   <= '0;
    end else begin
      sib_shift_q <= sib_shift_d;
      sib_upd_q   <= sib_upd_d;
      sib_err_q   <= sib_err_d;
    end
  end

  // Instrument gating uses the registered open state, so a segment being
  // closed still sees its final Update-DR; TDI into segment 0 is held low
  // during reset so every instrument-facing output is quiet.
  always_comb begin
    inst_select  = {N_SEG{ijtag_select}} & sib_upd_q;
    inst_capture = {N_SEG{ijtag_select & ijtag_capture}} & sib_upd_q;
    inst_shift   = {N_SEG{ijtag_select & ijtag_shift}} & sib_upd_q;
    inst_update  = {N_SEG{ijtag_select & ijtag_update}} & sib_upd_q;
    inst_tdi     = seg_in & {N_SEG{TRST_n}};
    ijtag_tdo    = sib_shift_q[N_SEG-1];
    sib_open     = sib_upd_q;
    sib_err      = sib_err_q;
  end

endmodule

// File: tb/tb_ijtag_sib_network.sv
// Directed bench for ijtag_sib_network (N_SEG=4) with 8-bit instrument
// shift-register models hanging off each segment.
module tb_ijtag_sib_network;

  localparam int N = 4;

  logic         TCK = 1'b0;
  logic         TRST_n = 1'b0;
  logic         sel = 1'b0, cap = 1'b0, sh = 1'b0, upd = 1'b0, tdi = 1'b0;
  logic         tdo;
  logic [N-1:0] inst_ready = 4'b1111;
  logic [N-1:0] inst_tdo;
  logic [N-1:0] inst_select, inst_capture, inst_shift, inst_update, inst_tdi;
  logic [N-1:0] sib_open, sib_err;

  logic [7:0]   sr [N];
  logic [12:0]  expv;
  logic [31:0]  bits;

  int n_tot  = 0;
  int n_pass = 0;
  int n_fail = 0;

  ijtag_sib_network #(.N_SEG(N)) dut (
    .TCK          (TCK),
    .TRST_n       (TRST_n),
    .ijtag_select (sel),
    .ijtag_capture(cap),
    .ijtag_shift  (sh),
    .ijtag_update (upd),
    .ijtag_tdi    (tdi),
    .ijtag_tdo    (tdo),
    .inst_ready   (inst_ready),
    .inst_tdo     (inst_tdo),
    .inst_select  (inst_select),
    .inst_capture (inst_capture),
    .inst_shift   (inst_shift),
    .inst_update  (inst_update),
    .inst_tdi     (inst_tdi),
    .sib_open     (sib_open),
    .sib_err      (sib_err)
  );

  always #5 TCK = ~TCK;

  // Instrument models: 8-bit shift registers, MSB is scan-out.
  always @(posedge TCK) begin
    for (int i = 0; i < N; i++)
      if (inst_shift[i]) sr[i] <= {sr[i][6:0], inst_tdi[i]};
  end

  always_comb begin
    inst_tdo = '0;
    for (int i = 0; i < N; i++) inst_tdo[i] = sr[i][7];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tot++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drv(input logic s, input logic c, input logic h, input logic u, input logic d);
    @(negedge TCK);
    sel = s; cap = c; sh = h; upd = u; tdi = d;
    #1;
  endtask

  task automatic tick();
    @(posedge TCK);
    #1;
  endtask

  task automatic scan(input logic [31:0] b, input int n);
    for (int t = 0; t < n; t++) begin
      drv(1'b1, 1'b0, 1'b1, 1'b0, b[t]);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sr[0] = 8'hC3; sr[1] = 8'h00; sr[2] = 8'h00; sr[3] = 8'h00;

    // 1. reset state, then capture and shift 4 zeros
    sel = 1'b1; sh = 1'b1; tdi = 1'b1;
    #2;
    chk("rst_open", 32'(sib_open), 32'h0);
    chk("rst_err", 32'(sib_err), 32'h0);
    chk("rst_tdo", 32'(tdo), 32'h0);
    chk("rst_inst", 32'({inst_select, inst_capture, inst_shift, inst_update, inst_tdi}), 32'h0);
    tick();
    chk("rst_hold_tdo", 32'(tdo), 32'h0);
    @(negedge TCK);
    TRST_n = 1'b1; sel = 1'b0; sh = 1'b0; tdi = 1'b0;
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_cap_gate", 32'(inst_capture), 32'h0);
    tick();
    chk("t1_cap_tdo", 32'(tdo), 32'h0);
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("t1_shift_tdo", 32'(tdo), 32'h0);
    end
    chk("t1_open", 32'(sib_open), 32'h0);
    chk("t1_inst", 32'({inst_select, inst_capture, inst_shift, inst_update}), 32'h0);

    // 2. open SIB0, then read back through the 12-bit path
    scan(32'h8, 4);
    drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("t2_open", 32'(sib_open), 32'h1);
    chk("t2_select", 32'(inst_select), 32'h1);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t2_nosel_open", 32'(sib_open), 32'h1);
    chk("t2_nosel_gate", 32'(inst_select), 32'h0);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expv = 13'b0_1100_0011_1000;
    bits = 32'h4D8;
    chk("t2_stream0", 32'(tdo), 32'(expv[0]));
    for (int k = 1; k <= 12; k++) begin
      drv(1'b1, 1'b0, 1'b1, 1'b0, bits[k-1]);
      tick();
      chk("t2_stream", 32'(tdo), 32'(expv[k]));
    end
    chk("t2_inst0_data", 32'(sr[0]), 32'hB2);
    drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_upd_gate", 32'(inst_update), 32'h1);
    tick();
    chk("t2_reopen", 32'(sib_open), 32'h1);

    // 3. open SIB2 while instrument 2 is not ready
    inst_ready = 4'b1011;
    scan(32'hA, 12);
    drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("t3_open", 32'(sib_open), 32'h1);
    chk("t3_err", 32'(sib_err), 32'h4);

    // 4. open SIB1, drop its ready mid-shift
    scan(32'hC, 12);
    drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("t4_open", 32'(sib_open), 32'h3);
    chk("t4_err_keep", 32'(sib_err), 32'h4);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    scan(32'h0, 2);
    drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    inst_ready = 4'b1001;
    #1;
    chk("t4_pre_edge", 32'(sib_open), 32'h3);
    tick();
    chk("t4_drop_open", 32'(sib_open), 32'h1);
    chk("t4_drop_err", 32'(sib_err), 32'h6);
    chk("t4_shift_gate", 32'(inst_shift), 32'h1);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    inst_ready = 4'b1011;

    // 5. open SIB3, then close it and see its final update
    scan(32'h9, 12);
    drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("t5_open", 32'(sib_open), 32'h9);
    scan(32'h800, 20);
    drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_final_upd", 32'(inst_update), 32'h9);
    tick();
    chk("t5_closed", 32'(sib_open), 32'h1);
    chk("t5_upd_after", 32'(inst_update), 32'h1);

    // 6. SIBs 0 and 2 open, async reset mid Shift-DR
    inst_ready = 4'b1111;
    scan(32'hA, 12);
    drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("t6_open", 32'(sib_open), 32'h5);
    chk("t6_err_sticky", 32'(sib_err), 32'h6);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    scan(32'h0, 2);
    drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t6_shift_gate", 32'(inst_shift), 32'h5);
    #2;
    TRST_n = 1'b0;
    #1;
    chk("t6_rst_open", 32'(sib_open), 32'h0);
    chk("t6_rst_shift", 32'(inst_shift), 32'h0);
    chk("t6_rst_tdo", 32'(tdo), 32'h0);
    chk("t6_rst_err", 32'(sib_err), 32'h0);
    chk("t6_rst_tdi", 32'(inst_tdi), 32'h0);
    @(negedge TCK);
    TRST_n = 1'b1; sel = 1'b0; sh = 1'b0; tdi = 1'b0;
    tick();
    chk("t6_post_open", 32'(sib_open), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
